// File: rtl/plat_pkg.sv
// Shared types and constants for the platform type generator.
// Per-level cumulative draw thresholds live here.
package plat_pkg;

  typedef enum logic [2:0] {
    GREEN  = 3'b000,
    WHITE  = 3'b001,
    BLUE   = 3'b010,
    YELLOW = 3'b011,
    BROWN  = 3'b100
  } plat_type_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE
  } plat_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [1:0] MAX_NONGREEN = 2'd3;

  // Exclusive upper bounds, indexed by level (element 0 = L0)
  localparam logic [3:0][7:0] THR_G =
    {8'd24, 8'd40, 8'd64, 8'd96};
  localparam logic [3:0][7:0] THR_W =
    {8'd56, 8'd72, 8'd88, 8'd112};
  localparam logic [3:0][7:0] THR_B =
    {8'd96, 8'd104, 8'd112, 8'd128};
  localparam logic [3:0][7:0] THR_Y =
    {8'd112, 8'd116, 8'd120, 8'd128};

  function automatic plat_type_t lookup(
    input logic [6:0] r,
    input logic [1:0] lvl
  );
    logic [7:0] v;
    v = {1'b0, r};
    if (v < THR_G[lvl]) return GREEN;
    if (v < THR_W[lvl]) return WHITE;
    if (v < THR_B[lvl]) return BLUE;
    if (v < THR_Y[lvl]) return YELLOW;
    return BROWN;
  endfunction

endpackage

// File: rtl/plat_lfsr16.sv
// 16-bit right-shifting Galois LFSR with load,
// enable and a guard against the all-zero lock-up state.
module plat_lfsr16
  import plat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [6:0]  rnd
);

  localparam logic [15:0] SEED_NZ =
    (SEED == 16'h0) ? 16'h0001 : SEED;

  logic [15:0] q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= SEED_NZ;
    end else if (load) begin
      q <= (load_val == 16'h0) ? 16'h0001 : load_val;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0);
    end
  end

  assign rnd = q[6:0];

endmodule

// File: rtl/plat_type_gen.sv
// Platform type generator: LFSR draw, level-weighted
// lookup and playability constraints, one strobe per spawn.
module plat_type_gen
  import plat_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] LVL_STEP  = 16'd500
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        spawn_req,
  input  logic        score_tick,
  input  logic        freeze,
  input  logic        lfsr_load,
  input  logic [15:0] lfsr_val,
  output logic [2:0]  type_trigger,
  output logic        type_valid,
  output logic [1:0]  level,
  output logic        req_drop
);

  plat_state_t state, state_nxt;
  plat_type_t  type_q, calc_type, draw;

  logic [6:0]  lfsr_rnd;
  logic [6:0]  sample;
  logic [6:0]  r_q;
  logic        pending;
  logic        prev_brown;
  logic [1:0]  ng_cnt;
  logic [15:0] score_cnt;
  logic        take;

  plat_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .en       (!freeze),
    .load     (lfsr_load),
    .load_val (lfsr_val),
    .rnd      (lfsr_rnd)
  );

  assign sample = lfsr_load ? lfsr_val[6:0] : lfsr_rnd;
  assign take   = spawn_req || pending;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!freeze) begin
      unique case (state)
        S_IDLE:  if (take) state_nxt = S_CALC;
        S_CALC:  state_nxt = S_ISSUE;
        S_ISSUE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    type_valid = (state == S_ISSUE) && !freeze;
  end

  always_comb begin
    draw = lookup(r_q, level);
    calc_type = draw;
    if (ng_cnt == MAX_NONGREEN) begin
      calc_type = GREEN;
    end else if (prev_brown && draw == BROWN) begin
      calc_type = GREEN;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q        <= '0;
      pending    <= 1'b0;
      req_drop   <= 1'b0;
      type_q     <= GREEN;
      prev_brown <= 1'b0;
      ng_cnt     <= '0;
    end else if (!freeze) begin
      if (state == S_IDLE) begin
        if (take) begin
          r_q <= sample;
          // a fresh request colliding with the pending one stays queued
          pending <= spawn_req && pending;
        end
      end else if (spawn_req) begin
        if (!pending) pending  <= 1'b1;
        else          req_drop <= 1'b1;
      end
      if (state == S_CALC) begin
        type_q <= calc_type;
      end
      if (state == S_ISSUE) begin
        prev_brown <= (type_q == BROWN);
        if (type_q == GREEN)
          ng_cnt <= '0;
        else if (ng_cnt != MAX_NONGREEN)
          ng_cnt <= ng_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_cnt <= '0;
      level     <= '0;
    end else if (score_tick && !freeze) begin
      if (score_cnt == LVL_STEP - 16'd1) begin
        score_cnt <= '0;
        if (level != 2'd3) level <= level + 2'd1;
      end else begin
        score_cnt <= score_cnt + 16'd1;
      end
    end
  end

  assign type_trigger = type_q;

endmodule

// File: tb/tb_plat_type_gen.sv
// Scoreboard bench for plat_type_gen: expected codes are
// queued at request time and popped on each strobe.
module tb_plat_type_gen;

  logic        Clk;
  logic        Reset_n;
  logic        spawn_req;
  logic        score_tick;
  logic        freeze;
  logic        lfsr_load;
  logic [15:0] lfsr_val;
  logic [2:0]  type_trigger;
  logic        type_valid;
  logic [1:0]  level;
  logic        req_drop;

  int n_vec;
  int n_err;
  int cyc;
  int n0;
  logic [2:0] sb[$];
  int strobes[$];
  logic [2:0] last_tt;

  plat_type_gen dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .spawn_req    (spawn_req),
    .score_tick   (score_tick),
    .freeze       (freeze),
    .lfsr_load    (lfsr_load),
    .lfsr_val     (lfsr_val),
    .type_trigger (type_trigger),
    .type_valid   (type_valid),
    .level        (level),
    .req_drop     (req_drop)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // one loaded request, with the N+2 latency checked
  task automatic req(
    input logic [6:0] r,
    input logic [2:0] e
  );
    spawn_req = 1'b1;
    lfsr_load = 1'b1;
    lfsr_val  = {9'h0, r};
    sb.push_back(e);
    step();
    spawn_req = 1'b0;
    lfsr_load = 1'b0;
    @(negedge Clk);
    chk("lat_n1", type_valid, 0);
    @(negedge Clk);
    chk("lat_n2", type_valid, 1);
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      score_tick = 1'b1;
      step();
    end
    score_tick = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      last_tt = 3'b000;
    end else if (type_valid) begin
      strobes.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        chk("type", type_trigger, sb.pop_front());
      end
      last_tt = type_trigger;
    end else begin
      chk("hold", type_trigger, last_tt);
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset_n = 1'b0;
    spawn_req = 1'b0;
    score_tick = 1'b0;
    freeze = 1'b0;
    lfsr_load = 1'b0;
    lfsr_val = 16'h0;
    step();
    step();
    Reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("rst_outs",
          {type_trigger, type_valid, level, req_drop}, 0);
    end
    step();

    req(7'd80, 3'b000);
    req(7'd100, 3'b001);
    req(7'd127, 3'b010);

    // three back-to-back pulses: one accepted, one queued, one lost
    chk("drop_before", req_drop, 0);
    strobes.delete();
    sb.push_back(3'b000);
    sb.push_back(3'b000);
    spawn_req = 1'b1;
    lfsr_load = 1'b1;
    lfsr_val  = 16'h0010;
    step();
    n0 = cyc;
    step();
    step();
    spawn_req = 1'b0;
    step();
    lfsr_load = 1'b0;
    repeat (4) step();
    chk("b2b_count", strobes.size(), 2);
    if (strobes.size() == 2) begin
      chk("b2b_first", strobes[0] - n0, 1);
      chk("b2b_gap", strobes[1] - strobes[0], 3);
    end
    chk("drop_after", req_drop, 1);

    // freeze while the request sits in CALC
    strobes.delete();
    spawn_req = 1'b1;
    lfsr_load = 1'b1;
    lfsr_val  = 16'd100;
    sb.push_back(3'b001);
    step();
    spawn_req = 1'b0;
    lfsr_load = 1'b0;
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("frz_novalid", type_valid, 0);
      step();
      spawn_req = (i == 1);
    end
    spawn_req = 1'b0;
    freeze = 1'b0;
    @(negedge Clk);
    chk("frz_drop_n0", type_valid, 0);
    @(negedge Clk);
    chk("frz_drop_n1", type_valid, 1);
    step();
    repeat (4) step();
    chk("frz_count", strobes.size(), 1);

    ticks(499);
    chk("lvl_499", level, 0);
    ticks(1);
    chk("lvl_500", level, 1);
    ticks(1000);
    chk("lvl_1500", level, 3);
    ticks(500);
    chk("lvl_sat", level, 3);

    req(7'd120, 3'b100);
    req(7'd127, 3'b000);
    req(7'd30, 3'b001);
    req(7'd30, 3'b001);
    req(7'd30, 3'b001);
    req(7'd30, 3'b000);

    // asynchronous reset with a request in CALC
    spawn_req = 1'b1;
    lfsr_load = 1'b1;
    lfsr_val  = 16'h0;
    step();
    spawn_req = 1'b0;
    lfsr_load = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_tt", type_trigger, 0);
    chk("arst_valid", type_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_drop", req_drop, 0);
    repeat (3) step();
    Reset_n = 1'b1;
    repeat (6) step();
    chk("post_rst_level", level, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
